data_mem_resp: RTL

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 78 +++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port word memory answering CPU reads/writes after a fixed wait,
// with misaligned or out-of-range addresses rejected through addr_err.
module data_mem_resp #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        addr_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] idx_q, acc_idx;
  logic [31:0] data_q, acc_data;
  logic wr_q, err_q, req, bad, acc, acc_wr;
  logic [31:0] ram [2**ADDR_WIDTH];
  assign req = mem_ren | mem_wen;
  assign bad = (mem_addr[1:0] != 2'b0) || ((mem_addr >> (ADDR_WIDTH + 2)) != 32'b0);
  // With no wait cycles the access happens at the capture edge, so it uses the live inputs.
  assign acc_idx  = state == IDLE ? mem_addr[ADDR_WIDTH+1:2] : idx_q;
  assign acc_data = state == IDLE ? mem_dout : data_q;
  assign acc_wr   = state == IDLE ? mem_wen : wr_q;
  assign mem_ack   = state == DONE;
  assign addr_err  = state == DONE && err_q;
  assign mem_stall = !cpu_rst && ((state == IDLE && req) || state == BUSY);
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    acc = 1'b0;
    if (state == IDLE && req) begin
      if (bad) state_nxt = DONE;
      else if (WAIT_CYCLES == 0) begin
        state_nxt = DONE;
        acc = 1'b1;
      end else begin
        state_nxt = BUSY;
        cnt_nxt = 4'(WAIT_CYCLES - 1);
      end
    end else if (state == BUSY) begin
      state_nxt = cnt == 4'd0 ? DONE : BUSY;
      cnt_nxt = cnt == 4'd0 ? cnt : cnt - 4'd1;
      acc = cnt == 4'd0;
    end else if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_din <= '0;
      idx_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (state == IDLE && req) begin
        idx_q <= mem_addr[ADDR_WIDTH+1:2];
        data_q <= mem_dout;
        wr_q <= mem_wen;
        err_q <= bad;
      end
      if (acc && !acc_wr) mem_din <= ram[acc_idx];
    end
  end
  // The array is deliberately outside the reset domain so it keeps its contents.
  always_ff @(posedge clk) begin
    if (acc && acc_wr && !cpu_rst) ram[acc_idx] <= acc_data;
  end
endmodule
